rl_queue_serializer: RTL

Read-side companion for the fall-through queue: pops DBITS-wide entries from a queue's read port and emits them as a valid/ready stream of OBITS-wide beats, least-significant slice first. It sits between a queue's q/empty/re port and a narrow consumer such as a byte-wide bus or a debug/trace port. It sustains one beat per cycle with no bubble between consecutive words.

---
 rtl/rl_queue_serializer_if.sv | 26 ++
 rtl/rl_queue_serializer.sv | 67 ++++++
 2 files changed

// File: rtl/rl_queue_serializer_if.sv
// Queue read port plus beat stream of the serializer, with its control strobes.
interface rl_queue_serializer_if #(
  parameter int DBITS = 32,
  parameter int OBITS = 8
);
  logic             clr_i;
  logic             ena_i;
  logic             q_empty_i;
  logic [DBITS-1:0] q_d_i;
  logic             q_re_o;
  logic             valid_o;
  logic             ready_i;
  logic [OBITS-1:0] data_o;
  logic             last_o;
  logic             busy_o;

  modport master (
    output clr_i, ena_i, q_empty_i, q_d_i, ready_i,
    input  q_re_o, valid_o, data_o, last_o, busy_o
  );

  modport slave (
    input  clr_i, ena_i, q_empty_i, q_d_i, ready_i,
    output q_re_o, valid_o, data_o, last_o, busy_o
  );
endinterface

// File: rtl/rl_queue_serializer.sv
// Pops DBITS-wide queue entries and streams them out as OBITS-wide beats, LSB slice first,
// refilling on the last accepted beat so consecutive words leave without a bubble.
module rl_queue_serializer #(
  parameter int DBITS = 32,
  parameter int OBITS = 8
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  rl_queue_serializer_if.slave bus
);
  localparam int RATIO = DBITS / OBITS;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state;
  logic [DBITS-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             valid;
  logic             last;
  logic             accept;
  logic             load;

  function automatic logic [DBITS-1:0] next_slice(input logic [DBITS-1:0] v);
    return v >> OBITS;
  endfunction

  assign valid  = (state == SHIFT);
  assign last   = valid & (cnt == CNT_LAST);
  assign accept = valid & bus.ready_i;
  // Reset is folded in so the queue is never popped while the block is held in reset.
  assign load   = rst_ni & bus.ena_i & ~bus.clr_i & ~bus.q_empty_i & (~valid | (accept & last));

  assign bus.q_re_o  = load;
  assign bus.valid_o = valid;
  assign bus.busy_o  = valid;
  assign bus.last_o  = last;
  assign bus.data_o  = hold[OBITS-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else if (bus.clr_i) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else if (bus.ena_i) begin
      if (load) begin
        hold  <= bus.q_d_i;
        cnt   <= '0;
        state <= SHIFT;
      end else if (accept) begin
        if (!last) begin
          hold <= next_slice(hold);
          cnt  <= cnt + CW'(1);
        end else begin
          state <= IDLE;
          cnt   <= '0;
          hold  <= '0;
        end
      end
    end
  end
endmodule
